serial_add_seq: RTL and testbench



---
 rtl/serial_add_seq_if.sv | 39 +++
 rtl/full_adder.sv | 11 +
 rtl/serial_add_seq.sv | 140 ++++++++++++++
 tb/tb_serial_add_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/serial_add_seq_if.sv
// Operand/result handshake bundle for serial_add_seq.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    // Producer/consumer side of the adder
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout,
`ifdef SERIAL_ADD_OVF_EN
        input  ovf,
`endif
        input  busy
    );

    // Adder side
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout,
`ifdef SERIAL_ADD_OVF_EN
        output ovf,
`endif
        output busy
    );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the bit-serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder controller: one operand bit pair per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_seq_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               w_fa_sum;
    logic               w_fa_carry;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_sum_sh_nxt;

    full_adder u_fa (
        .a     (r_a_sh[0]),
        .b     (r_b_sh[0]),
        .cin   (r_carry),
        .sum   (w_fa_sum),
        .carry (w_fa_carry)
    );

    assign w_accept = (r_state == S_IDLE) && bus.in_valid;
    assign w_last   = (r_state == S_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));

    // New sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_sh_nxt = w_fa_sum;
        end else begin : g_sum_wn
            assign w_sum_sh_nxt = {w_fa_sum, r_sum_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)        w_state_nxt = S_DONE;
            S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
            default:                    w_state_nxt = S_IDLE;
        endcase
    end

    // Serial datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == S_SHIFT) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= w_sum_sh_nxt;
            r_carry  <= w_fa_carry;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Result registers load only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_sum_sh_nxt;
            r_cout <= w_fa_carry;
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic r_ovf;

    // Carry into MSB differs from carry out of MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_fa_carry;
        end
    end

    assign bus.ovf = r_ovf;
`endif

    // Handshake/status flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: directed cases, abort-by-reset, random stream.
module tb_serial_add_seq;
    localparam int unsigned WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    serial_add_seq_if #(.WIDTH(WIDTH)) bus ();

    serial_add_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer addition, signed range test for overflow
    function automatic exp_t ref_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                     input logic cin);
        exp_t        r;
        int unsigned u;
        int          s;
        int          sa;
        int          sbv;
        u   = 32'(a) + 32'(b) + 32'(cin);
        sa  = $signed(a);
        sbv = $signed(b);
        s   = sa + sbv + 32'(cin);
        r.sum  = u[WIDTH-1:0];
        r.cout = u[WIDTH];
        r.ovf  = (s > 127) || (s < -128);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input int stall, input bit poke);
        int   guard;
        int   lat;
        exp_t e;
        guard = 0;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("in_ready_before_accept", 64'(bus.in_ready), 64'(1));
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
        bus.in_valid = 1'b1;
        bus.out_ready = (stall == 0);
        sb.push_back(ref_add(a, b, cin));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("busy_after_accept", 64'(bus.busy), 64'(1));
        chk("in_ready_after_accept", 64'(bus.in_ready), 64'(0));
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 3 * WIDTH) begin
            if (poke && lat < 2) begin
                bus.a        = ~a;
                bus.b        = a ^ 8'h5A;
                bus.cin      = ~cin;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        chk("latency", 64'(lat), 64'(WIDTH));
        e = sb.pop_front();
        chk("sum", 64'(bus.sum), 64'(e.sum));
        chk("cout", 64'(bus.cout), 64'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
        chk("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("stall_sum", 64'(bus.sum), 64'(e.sum));
            chk("stall_cout", 64'(bus.cout), 64'(e.cout));
            chk("stall_out_valid", 64'(bus.out_valid), 64'(1));
            chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("out_valid_after_pop", 64'(bus.out_valid), 64'(0));
        chk("in_ready_after_pop", 64'(bus.in_ready), 64'(1));
        chk("busy_after_pop", 64'(bus.busy), 64'(0));
        chk("sum_held_in_idle", 64'(bus.sum), 64'(e.sum));
    endtask

    initial begin
        bit seen;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_sum", 64'(bus.sum), 64'(0));
        chk("rst_cout", 64'(bus.cout), 64'(0));
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_ovf", 64'(bus.ovf), 64'(0));
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases
        run_txn(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_txn(8'h7F, 8'h01, 1'b0, 1, 1'b0);
        run_txn(8'h80, 8'h80, 1'b0, 0, 1'b0);
        run_txn(8'h00, 8'h00, 1'b1, 2, 1'b0);
        run_txn(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        // Backpressure plus ignored in_valid during SHIFT
        run_txn(8'hA5, 8'h3C, 1'b1, 5, 1'b1);

        // Abort by reset during the third SHIFT cycle
        bus.a        = 8'hC3;
        bus.b        = 8'h11;
        bus.cin      = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", 64'(bus.in_ready), 64'(1));
        chk("abort_sum", 64'(bus.sum), 64'(0));
        chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        bus.out_ready = 1'b0;
        chk("abort_no_result", 64'(seen), 64'(0));
        run_txn(8'h12, 8'h34, 1'b0, 0, 1'b0);
        chk("post_abort_sum_46", 64'(bus.sum), 64'(8'h46));

        // Back-to-back random stream with random stalls
        for (int t = 0; t < 10; t++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            logic             rc;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom_range(0, 1));
            run_txn(ra, rb, rc, int'($urandom_range(0, 3)), 1'b0);
        end
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
